mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the instruction-fetch stage and the data (MEM) stage of the pipelined core. It grants at most one outstanding transaction at a time and routes each response back to the requester that owns it. When a branch redirect kills an in-flight fetch, its response is discarded. The arbiter exports per-requester stall signals so the fetch stage can hold its PC and the pipeline can freeze while waiting.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win; 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  branch redirect; discard any outstanding fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  fetch waiting (if_req & ~if_rvalid)
- d_req  in  1  data request, held until granted
- d_we  in  1  write when 1
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  4  byte strobes
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  DATA_W  load data
- d_stall  out  1  data waiting (d_req & ~d_rvalid)
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/4  forwarded from the granted requester
- mem_rvalid  in  1  one pulse per accepted request (reads and writes)
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid

## Operation
- States: IDLE (no transaction outstanding) and WAIT (one transaction outstanding). Registers: state, owner (OWN_IF/OWN_D), drop, starve_cnt.
- Issue is allowed in IDLE, and in WAIT during the cycle mem_rvalid arrives (back-to-back issue).
- When issue is allowed and a request is present:
  - Data wins unless starve_cnt == STARVE_MAX and if_req is high; in that case fetch wins.
  - Only one grant is asserted. mem_req = if_gnt | d_gnt, and the mem_* fields are muxed from the winner.
- On grant: next state is WAIT, owner is set to the winner, and drop is cleared.
- On mem_rvalid in WAIT with no new grant: next state is IDLE.
- Starvation counter:
  - starve_cnt increments, saturating, whenever d_gnt is asserted while if_req is high.
  - starve_cnt clears on if_gnt.
  - Width is $clog2(STARVE_MAX+1).
- Response routing (combinational from mem_rvalid/mem_rdata):
  - if_rvalid = mem_rvalid & state==WAIT & owner==OWN_IF & ~drop & ~if_kill.
  - d_rvalid = mem_rvalid & state==WAIT & owner==OWN_D.
  - rdata outputs pass mem_rdata when the matching rvalid is high, else 0.
- Kill handling:
  - if_kill while state==WAIT and owner==OWN_IF sets drop. The response is then consumed and not forwarded.
  - if_kill in the same cycle as the fetch mem_rvalid suppresses if_rvalid.
  - if_kill with no fetch outstanding has no effect.
  - if_kill never blocks a new fetch grant in the same cycle.
- A mem_rvalid while state==IDLE is spurious. It is ignored and routed nowhere.

## Timing
- Reset: state=IDLE, owner=OWN_IF, drop=0, starve_cnt=0. While rst is high, all outputs are 0, including the gnt, rvalid, stall and mem_req outputs.
- Reset mid-transaction: the arbiter returns to IDLE immediately. The late mem_rvalid of the lost transaction is treated as spurious.
- Grant is same-cycle (combinational from req and state). Response is forwarded with zero added latency.
- Minimum request-to-response time equals the memory latency. Back-to-back issue gives one transaction per memory latency.
- A data request that arrives together with a mem_rvalid for a fetch is granted in that same cycle.

## Structure
- Package riscv_mem_pkg holds:
  - owner_t enum (OWN_IF, OWN_D)
  - arb_state_t enum (IDLE, WAIT)
  - the STRB_W=4 constant
- Sub-module mem_arb_starve_ctr holds the saturating counter and the force_if output. Everything else lives in mem_arbiter.

## Test plan
- Fetch only, memory latency 2: if_req at 0x0, 0x4, 0x8 → three if_gnt pulses two cycles apart, if_rdata matches memory, d_* outputs stay 0.
- Simultaneous if_req and d_req (load 0x100) → d_gnt first, if_stall held high; fetch is granted in the cycle d_rvalid fires.
- d_req held continuously, STARVE_MAX=4, if_req high → four data grants, then one if_gnt, then starve_cnt reads 0.
- Fetch outstanding, if_kill pulsed one cycle after grant → if_rvalid never asserts for that fetch; the next fetch is granted on the mem_rvalid cycle and its data is forwarded.
- if_kill coincident with fetch mem_rvalid → if_rvalid=0 that cycle, state returns to IDLE.
- rst asserted during WAIT, memory returns mem_rvalid after reset → no rvalid outputs, state=IDLE, a new if_req is granted normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Owner and state encodings are visible to the bench for inspection.
package riscv_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam int STRB_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of fetch denials; force_if hands the next grant to fetch.
module mem_arb_starve_ctr #(
    parameter int  STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             force_if
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_if = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// One transaction in flight; responses are routed to the owner with no added latency.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state;
    owner_t           owner;
    logic             drop;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    logic issue_ok;
    logic if_win;
    logic d_win;
    logic resp_hit;

    // Issue in IDLE, or in WAIT on the response cycle for back-to-back traffic.
    // Gating with rst keeps every output low while reset is held.
    assign issue_ok = ~rst & ((state == IDLE) | mem_rvalid);
    assign if_win   = issue_ok & if_req & (force_if | ~d_req);
    assign d_win    = issue_ok & d_req & ~(force_if & if_req);

    assign if_gnt  = if_win;
    assign d_gnt   = d_win;
    assign mem_req = if_win | d_win;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (d_win) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end else if (if_win) begin
            mem_addr  = if_addr;
        end
    end

    // A response in IDLE is spurious (e.g. from a transaction lost to reset).
    assign resp_hit  = ~rst & mem_rvalid & (state == WAIT);
    assign if_rvalid = resp_hit & (owner == OWN_IF) & ~drop & ~if_kill;
    assign d_rvalid  = resp_hit & (owner == OWN_D);

    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid  ? mem_rdata : '0;

    assign if_stall = ~rst & if_req & ~if_rvalid;
    assign d_stall  = ~rst & d_req & ~d_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_IF;
            drop  <= 1'b0;
        end else if (mem_req) begin
            state <= WAIT;
            owner <= d_win ? OWN_D : OWN_IF;
            drop  <= 1'b0;
        end else begin
            if ((state == WAIT) && mem_rvalid) begin
                state <= IDLE;
            end
            // A redirect orphans the outstanding fetch; its response is swallowed.
            if ((state == WAIT) && (owner == OWN_IF) && if_kill) begin
                drop <= 1'b1;
            end
        end
    end

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (d_win & if_req),
        .clr      (if_win),
        .cnt      (starve_cnt),
        .force_if (force_if)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven cycle vectors for mem_arbiter, plus an asynchronous-reset sequence.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_gnt, if_rvalid, if_stall;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid, d_stall;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        rst;
        logic        if_req;
        logic        if_kill;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
    } in_t;

    // flags = {if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall, mem_req, mem_we}
    typedef struct packed {
        logic [7:0]  flags;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } out_t;

    // exp_int = state*16 + starve_cnt, or -1 to skip the internal check
    typedef struct {
        string name;
        in_t   i;
        out_t  o;
        int    exp_int;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic vec(input string nm,
                       input logic rst_v, input logic ifr, input logic kill, input logic [31:0] ifa,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] dst, input logic mrv, input logic [31:0] mrd,
                       input logic [7:0] fl, input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic [3:0] mst, input logic [31:0] ird, input logic [31:0] drd,
                       input int eint);
        vec_t v;
        v.name    = nm;
        v.i       = '{rst_v, ifr, kill, ifa, dr, dwe, da, dwd, dst, mrv, mrd};
        v.o       = '{fl, maddr, mwd, mst, ird, drd};
        v.exp_int = eint;
        vecs.push_back(v);
    endtask

    function automatic out_t sample_out();
        out_t o;
        o.flags     = {if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall, mem_req, mem_we};
        o.mem_addr  = mem_addr;
        o.mem_wdata = mem_wdata;
        o.mem_wstrb = mem_wstrb;
        o.if_rdata  = if_rdata;
        o.d_rdata   = d_rdata;
        return o;
    endfunction

    function automatic int sample_int();
        return int'(dut.state) * 16 + int'(dut.starve_cnt);
    endfunction

    task automatic drive(input in_t i);
        rst        = i.rst;
        if_req     = i.if_req;
        if_kill    = i.if_kill;
        if_addr    = i.if_addr;
        d_req      = i.d_req;
        d_we       = i.d_we;
        d_addr     = i.d_addr;
        d_wdata    = i.d_wdata;
        d_wstrb    = i.d_wstrb;
        mem_rvalid = i.mem_rvalid;
        mem_rdata  = i.mem_rdata;
    endtask

    initial begin
        //   name      rst ifr kil if_addr        dr we d_addr         d_wdata        strb   mrv mem_rdata      flags         mem_addr       mem_wdata      strb   if_rdata       d_rdata        int
        vec("rst_hold", 1, 1, 0, 32'h0000_0000, 1, 1, 32'h0000_0100, 32'hFFFF_0000, 4'hF, 1, 32'h0000_DEAD, 8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        // fetch only, memory latency 2
        vec("a1_gnt0",  0, 1, 0, 32'h0000_0000, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("a2_wait",  0, 1, 0, 32'h0000_0004, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b001_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("a3_gnt4",  0, 1, 0, 32'h0000_0004, 0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h1111_1111, 8'b110_000_10, 32'h0000_0004, 32'h0,         4'h0, 32'h1111_1111, 32'h0,         -1);
        vec("a4_wait",  0, 1, 0, 32'h0000_0008, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b001_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("a5_gnt8",  0, 1, 0, 32'h0000_0008, 0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h2222_2222, 8'b110_000_10, 32'h0000_0008, 32'h0,         4'h0, 32'h2222_2222, 32'h0,         -1);
        vec("a6_wait",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("a7_last",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h3333_3333, 8'b010_000_00, 32'h0,         32'h0,         4'h0, 32'h3333_3333, 32'h0,         -1);
        // simultaneous fetch and load: data first, fetch on the d_rvalid cycle
        vec("b1_dwin",  0, 1, 0, 32'h0000_000C, 1, 0, 32'h0000_0100, 32'h0,         4'h0, 0, 32'h0,         8'b001_101_10, 32'h0000_0100, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("b2_wait",  0, 1, 0, 32'h0000_000C, 1, 0, 32'h0000_0100, 32'h0,         4'h0, 0, 32'h0,         8'b001_001_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h11);
        vec("b3_ifgnt", 0, 1, 0, 32'h0000_000C, 0, 0, 32'h0,         32'h0,         4'h0, 1, 32'hAAAA_0001, 8'b101_010_10, 32'h0000_000C, 32'h0,         4'h0, 32'h0,         32'hAAAA_0001, 'h11);
        vec("b4_ifrsp", 0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_0013, 8'b010_000_00, 32'h0,         32'h0,         4'h0, 32'h0000_0013, 32'h0,         'h10);
        // starvation: four stores win, then fetch is forced through
        vec("c1_st1",   0, 1, 0, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 0, 32'h0,         8'b001_101_11, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 32'h0,         32'h0,         'h00);
        vec("c2_st2",   0, 1, 0, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 32'h0,         8'b001_110_11, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 32'h0,         32'h0,         'h11);
        vec("c3_st3",   0, 1, 0, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 32'h0,         8'b001_110_11, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 32'h0,         32'h0,         'h12);
        vec("c4_st4",   0, 1, 0, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 32'h0,         8'b001_110_11, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 32'h0,         32'h0,         'h13);
        vec("c5_force", 0, 1, 0, 32'h0000_0010, 1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 32'h0,         8'b101_010_10, 32'h0000_0010, 32'h0,         4'h0, 32'h0,         32'h0,         'h14);
        vec("c6_dnext", 0, 0, 0, 32'h0,         1, 1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 32'h0000_0013, 8'b010_101_11, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 32'h0000_0013, 32'h0,         'h10);
        vec("c7_ack",   0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0,         8'b000_010_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        // kill one cycle after the fetch grant
        vec("d1_gnt",   0, 1, 0, 32'h0000_0020, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0020, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("d2_kill",  0, 1, 1, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b001_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("d3_drop",  0, 1, 0, 32'h0000_0040, 0, 0, 32'h0,         32'h0,         4'h0, 1, 32'hBAD0_BAD0, 8'b101_000_10, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("d4_fwd",   0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h600D_F00D, 8'b010_000_00, 32'h0,         32'h0,         4'h0, 32'h600D_F00D, 32'h0,         -1);
        // kill coincident with response, spurious rvalid, kill without owner
        vec("e1_gnt",   0, 1, 0, 32'h0000_0050, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0050, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("e2_kilrv", 0, 0, 1, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h1234_5678, 8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("e3_spur",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_0077, 8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("e4_kilgn", 0, 1, 1, 32'h0000_0060, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0060, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("e5_fwd",   0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h6060_6060, 8'b010_000_00, 32'h0,         32'h0,         4'h0, 32'h6060_6060, 32'h0,         -1);
        vec("e6_dld",   0, 0, 0, 32'h0,         1, 0, 32'h0000_0300, 32'h0,         4'h0, 0, 32'h0,         8'b000_101_10, 32'h0000_0300, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("e7_kild",  0, 0, 1, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h10);
        vec("e8_drsp",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_D00D, 8'b000_010_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0000_D00D, -1);
        // reset mid-transaction, late response is spurious, then normal traffic
        vec("f1_gnt",   0, 1, 0, 32'h0000_0070, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0070, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("f2_rst",   1, 1, 0, 32'h0000_0070, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("f3_late",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_0099, 8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("f4_gnt",   0, 1, 0, 32'h0000_0074, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b101_000_10, 32'h0000_0074, 32'h0,         4'h0, 32'h0,         32'h0,         'h00);
        vec("f5_b2b_d", 0, 0, 0, 32'h0,         1, 0, 32'h0000_0400, 32'h0,         4'h0, 1, 32'h7474_7474, 8'b010_101_10, 32'h0000_0400, 32'h0,         4'h0, 32'h7474_7474, 32'h0,         'h10);
        vec("f6_drsp",  0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h4040_4040, 8'b000_010_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h4040_4040, 'h10);
        vec("g_idle",   0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         8'b000_000_00, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         'h00);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check(vecs[k].name, 160'(sample_out()), 160'(vecs[k].o));
            if (vecs[k].exp_int >= 0) begin
                check({vecs[k].name, "_int"}, 160'(sample_int()), 160'(vecs[k].exp_int));
            end
        end

        // Asynchronous reset mid-cycle while a fetch is outstanding.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        #1;
        check("h_gnt", 160'({if_gnt, mem_req, mem_addr}), 160'({1'b1, 1'b1, 32'h0000_0080}));
        @(posedge clk);
        #1;
        check("h_wait", 160'(sample_int()), 160'('h10));
        #2;
        rst = 1'b1;
        #1;
        check("h_async_state", 160'(sample_int()), 160'('h00));
        check("h_async_outs", 160'(sample_out()), 160'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("h_regrant", 160'({if_gnt, if_stall, mem_addr}), 160'({1'b1, 1'b1, 32'h0000_0080}));
        @(negedge clk);
        if_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
